// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS main controller.
// Holds FSM state codes, extender op codes (also used by the extender),
// ALU op / next-PC / write-data / destination-register select codes,
// opcode and funct constants, and the one-hot instruction class type.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] EXT_NONE     = 3'b000;
  localparam logic [2:0] EXT_ZERO     = 3'b001;
  localparam logic [2:0] EXT_SIGN     = 3'b010;
  localparam logic [2:0] EXT_SIGN_SL2 = 3'b011;
  localparam logic [2:0] EXT_LUI      = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // One-hot instruction class; all-zero means the encoding is a nop.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
  } iclass_t;

  function automatic logic [2:0] ext_op_of(input iclass_t c);
    logic [2:0] r;
    r = EXT_NONE;
    if (c.ori)              r = EXT_ZERO;
    if (c.lw || c.sw)       r = EXT_SIGN;
    if (c.beq)              r = EXT_SIGN_SL2;
    if (c.lui)              r = EXT_LUI;
    return r;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   instr  in  32 : latched instruction word from the IR
//   cls    out    : one-hot instruction class (all zero = nop)
//   ext_op out 3  : immediate-extender op for this instruction
import mc_ctrl_pkg::*;

module mc_decode (
  input  logic [31:0] instr,
  output iclass_t     cls,
  output logic [2:0]  ext_op
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  // Register and immediate fields belong to the datapath, not the controller.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        cls.addu = (fn == FN_ADDU);
        cls.subu = (fn == FN_SUBU);
        cls.jr   = (fn == FN_JR);
      end
      OP_ORI: cls.ori = 1'b1;
      OP_LW:  cls.lw  = 1'b1;
      OP_SW:  cls.sw  = 1'b1;
      OP_BEQ: cls.beq = 1'b1;
      OP_LUI: cls.lui = 1'b1;
      OP_J:   cls.j   = 1'b1;
      OP_JAL: cls.jal = 1'b1;
      default: cls = '0;
    endcase
    ext_op = ext_op_of(cls);
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
// Sequences FETCH/DECODE/EXE/MEM/WB and drives write enables, mux selects,
// ALU op and extender op. Outputs are combinational from state and instr.
// Optional build macro: MC_CTRL_MEM_HS_EN -- FETCH and MEM wait for
// mem_ready; without it mem_ready is ignored and memory is single-cycle.
// Ports:
//   clk, reset (async, active-high)
//   instr[31:0], zero, mem_ready            : inputs
//   pc_we, ir_we, reg_we, mem_we, mem_req    : enables / request
//   ext_op[2:0], alu_op[2:0], alu_src_b      : extender / ALU controls
//   reg_dst[1:0], wd_sel[1:0], npc_sel[1:0]  : mux selects
//   instr_done                               : last cycle of an instruction
import mc_ctrl_pkg::*;

module mc_ctrl #(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic        mem_req,
  output logic [2:0]  ext_op,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [1:0]  npc_sel,
  output logic        instr_done
);

  state_t     state, state_nxt;
  iclass_t    cls;
  logic [2:0] dec_ext;
  logic       mem_ok;
  logic       is_nop;
  logic [4:0] unused_ra;

  // RA_IDX is applied by the register-file address mux on reg_dst=RD_RA.
  assign unused_ra = RA_IDX;

  mc_decode u_decode (
    .instr  (instr),
    .cls    (cls),
    .ext_op (dec_ext)
  );

`ifdef MC_CTRL_MEM_HS_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  assign is_nop = (cls == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_req    = 1'b0;
    ext_op     = EXT_NONE;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    reg_dst    = RD_RT;
    wd_sel     = WD_ALU;
    npc_sel    = NPC_PC4;
    instr_done = 1'b0;

    case (state)
      S_FETCH: begin
        // instr is the previous IR value here, so nothing below looks at it.
        mem_req = 1'b1;
        ir_we   = mem_ok;
        pc_we   = mem_ok;
        if (mem_ok) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ext_op = dec_ext;
        if (cls.j) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
        end
        if (cls.jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_RS;
        end
        if (cls.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
          reg_we  = 1'b1;
          reg_dst = RD_RA;
          wd_sel  = WD_PC4;
        end
        if (cls.j || cls.jr || cls.jal || is_nop) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end else begin
          state_nxt  = S_EXE;
        end
      end
      S_EXE: begin
        ext_op    = dec_ext;
        alu_src_b = cls.ori || cls.lui || cls.lw || cls.sw;
        if (cls.subu || cls.beq)     alu_op = ALU_SUB;
        else if (cls.ori || cls.lui) alu_op = ALU_OR;
        if (cls.beq) begin
          npc_sel    = NPC_BRANCH;
          pc_we      = zero;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_nxt  = S_MEM;
        end else begin
          state_nxt  = S_WB;
        end
      end
      S_MEM: begin
        ext_op  = dec_ext;
        mem_req = 1'b1;
        if (cls.sw) begin
          mem_we     = mem_ok;
          instr_done = mem_ok;
          if (mem_ok) state_nxt = S_FETCH;
        end else begin
          if (mem_ok) state_nxt = S_WB;
        end
      end
      S_WB: begin
        ext_op     = dec_ext;
        reg_we     = 1'b1;
        instr_done = 1'b1;
        reg_dst    = (cls.addu || cls.subu) ? RD_RD : RD_RT;
        wd_sel     = cls.lw ? WD_MEM : WD_ALU;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset overrides everything with side effects while it is held.
    if (reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      mem_req    = 1'b0;
      instr_done = 1'b0;
      ext_op     = EXT_NONE;
    end
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. It sequences FETCH/DECODE/EXE/MEM/WB per instruction and drives the write enables, mux selects, ALU op and immediate-extender op (`ext_op`) for the shared extender, ALU and memory. It sits beside the IR and reads the latched instruction word. It holds the only state machine in the core.

## Interface
Parameters:
- `RA_IDX`, 5'd31: register index written by `jal`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 32: IR output; stable from DECODE onward.
- `zero` in 1: ALU equality flag, valid in EXE.
- `mem_ready` in 1: memory handshake; used only with the macro.
- `pc_we`, `ir_we`, `reg_we`, `mem_we` out 1 each: write enables.
- `mem_req` out 1: memory access request.
- `ext_op` out 3: 001 zero-extend, 010 sign-extend, 011 sign-extend then <<2, 100 imm into high half, 000 none.
- `alu_op` out 3: 000 add, 001 sub, 010 or.
- `alu_src_b` out 1: 0 register, 1 extended immediate.
- `reg_dst` out 2: 00 rt, 01 rd, 10 `RA_IDX`.
- `wd_sel` out 2: 00 ALU, 01 memory, 10 PC+4.
- `npc_sel` out 2: 00 PC+4, 01 branch, 10 jump target, 11 rs.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.

## Operation
- Supported instructions:
  - `addu`: op 0, funct 100001.
  - `subu`: op 0, funct 100011.
  - `jr`: op 0, funct 001000.
  - `ori` 001101, `lw` 100011, `sw` 101011, `beq` 000100, `lui` 001111, `j` 000010, `jal` 000011.
  - Any other encoding is treated as a nop.
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- FETCH: `mem_req`=1, `ir_we`=1, `pc_we`=1, `npc_sel`=00. Always goes to DECODE.
- DECODE:
  - `j`, `jr`, `jal`, nop → FETCH with `instr_done`=1.
  - `j`: `pc_we`=1, `npc_sel`=10.
  - `jr`: `pc_we`=1, `npc_sel`=11.
  - `jal`: `pc_we`=1, `npc_sel`=10, plus `reg_we`=1, `reg_dst`=10, `wd_sel`=10 in the same cycle.
  - All other instructions → EXE.
- EXE:
  - `beq`: `alu_op`=sub, `npc_sel`=01, `pc_we`=`zero`, `instr_done`=1 → FETCH.
  - `lw`/`sw` → MEM.
  - ALU-class instructions → WB.
- MEM:
  - `sw`: `mem_req`=1, `mem_we`=1, `instr_done`=1 → FETCH.
  - `lw`: `mem_req`=1 → WB.
- WB:
  - `reg_we`=1, `instr_done`=1 → FETCH.
  - `lw`: `wd_sel`=01, `reg_dst`=00.
  - R-type: `reg_dst`=01.
  - `ori`/`lui`: `reg_dst`=00.
- `ext_op` is decoded from `instr` in DECODE through WB and is 000 in FETCH:
  - `ori` → 001.
  - `lw`/`sw` → 010.
  - `beq` → 011.
  - `lui` → 100.
  - All others → 000.
- `alu_src_b`=1 for `ori`/`lui`/`lw`/`sw`. `lui` uses `alu_op`=or against `$0`.
- Non-asserted outputs are 0 in every state.

## Timing
- All outputs are combinational from the state register and `instr`. The only registered element is the state.
- Reset: state goes to FETCH immediately. While `reset`=1, every `*_we`, `mem_req` and `instr_done` is forced to 0, and `ext_op`=000. FETCH begins on the first edge after release.
- Latency in cycles:
  - `j`/`jr`/`jal`: 2.
  - `beq`: 3.
  - R-type/`ori`/`lui`/`sw`: 4.
  - `lw`: 5.
- Reset asserted mid-instruction abandons it with no further write enables.
- `instr` changes during FETCH must not affect FETCH outputs.

## Configuration
- `MC_CTRL_MEM_HS_EN` defined:
  - FETCH and MEM hold while `mem_ready`=0.
  - `mem_req` stays 1 while holding.
  - `ir_we`, `pc_we` (FETCH) and `mem_we` and the MEM→next transition are gated by `mem_ready`.
  - `instr_done` for `sw` fires only in the ready cycle.
- Undefined: `mem_ready` is ignored, and every memory access completes in one cycle.

## Structure
- `mc_ctrl_pkg` holds:
  - state encodings.
  - `EXT_*` op codes, which are shared with the extender.
  - ALU op, `npc_sel`, `wd_sel` and `reg_dst` codes.
  - opcode and funct constants.
- One sub-module, `mc_decode`: combinational classifier from `instr` to one-hot instruction class plus `ext_op`. `mc_ctrl` holds the FSM and output logic.

## Test plan
- Reset asserted during EXE of `addu` → all enables 0 at once. After release, FETCH with `ir_we`=`pc_we`=1.
- `ori $1,$0,0x8000` → `ext_op`=001 in D/E/WB, `reg_we`=1 only in cycle 4, `instr_done` in cycle 4.
- `beq` twice, `zero`=1 then `zero`=0 → `pc_we`=1 with `npc_sel`=01 in EXE of the first; `pc_we`=0 in EXE of the second; `ext_op`=011 in both.
- `lw` → `wd_sel`=01 and `reg_we`=1 in cycle 5. `sw` → `mem_we`=1 in cycle 4, `reg_we` never 1.
- `jal` → in DECODE: `pc_we`=1, `npc_sel`=10, `reg_we`=1, `reg_dst`=10, `wd_sel`=10, `instr_done`=1. Then FETCH.
- With `MC_CTRL_MEM_HS_EN`, `sw` with `mem_ready` low for 3 cycles → MEM held 3 extra cycles, `mem_we` only in the ready cycle. Opcode 0x3F → nop in 2 cycles.
